// File: rtl/ibex_prefetch_buffer_nreq.sv
// Prefetch buffer for the 32-bit instruction bus with up to NumReqs outstanding requests.
//
// Returned words are queued in a FifoDepth-entry FIFO and handed to the IF stage one word at a
// time. Outstanding and to-be-discarded responses are tracked with counters, so any number of
// in-flight requests can be flushed by a branch. Halfword alignment is left to the aligner.
//
// Optional feature (macro IBEX_PREFETCH_BYPASS_EN): when defined, a response arriving while the
// FIFO is empty is presented on valid_o/rdata_o/err_o in the same cycle and, if ready_i is
// high, consumed without being written. When undefined, the output is purely registered.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   req_i                core wants instructions fetched
//   branch_i, addr_i     redirect to addr_i; flushes FIFO and in-flight data
//   ready_i              consumer accepts the head word
//   valid_o, rdata_o     head word valid / head instruction word
//   addr_o, err_o        address of head word / bus error on head word
//   instr_req_o, instr_gnt_i, instr_addr_o               bus request channel
//   instr_rdata_i, instr_err_i, instr_rvalid_i           bus response channel
//   busy_o               requests outstanding or being made
module ibex_prefetch_buffer_nreq #(
  parameter int unsigned NumReqs   = 2,
  parameter int unsigned FifoDepth = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,

  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        err_o,

  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  input  logic        instr_rvalid_i,

  output logic        busy_o
);

  localparam int unsigned CntW  = $clog2(NumReqs + 1);
  localparam int unsigned FCntW = $clog2(FifoDepth + 1);
  localparam int unsigned PtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

  if (NumReqs < 1 || NumReqs > 8) begin : gen_bad_num_reqs
    $fatal(1, "NumReqs must be in 1..8");
  end
  if (FifoDepth < NumReqs) begin : gen_bad_fifo_depth
    $fatal(1, "FifoDepth must be >= NumReqs");
  end

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (32'(p) == FifoDepth - 1) ? '0 : p + PtrW'(1);
  endfunction

  // Request-side state
  logic            pending_q;
  logic            pending_discard_q;
  logic [31:0]     stored_addr_q;
  logic [31:0]     fetch_addr_q, fetch_addr_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] discard_q, discard_d;

  // Output-side state
  logic [31:0]      out_addr_q, out_addr_d;
  logic [31:0]      fifo_rdata_q [FifoDepth];
  logic             fifo_err_q   [FifoDepth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FCntW-1:0] count_q, count_d;

  logic [31:0] occupancy;
  logic        space, room, new_req, gnt, stale_gnt;
  logic [31:0] req_addr, req_addr_aligned;
  logic        push, bypass, fifo_empty, fifo_wr, fifo_pop, pop;

  // The FIFO counts as empty in the branch cycle because it is being flushed.
  assign occupancy = (branch_i ? 32'd0 : 32'(count_q)) + 32'(outstanding_q) - 32'(discard_q);
  assign space     = occupancy < FifoDepth;
  assign room      = 32'(outstanding_q) < NumReqs;
  assign new_req   = req_i & ~pending_q & room & (space | branch_i);

  assign instr_req_o      = pending_q | new_req;
  assign req_addr         = pending_q ? stored_addr_q : (branch_i ? addr_i : fetch_addr_q);
  assign req_addr_aligned = req_addr & ~32'h3;
  assign instr_addr_o     = req_addr_aligned;

  assign gnt = instr_req_o & instr_gnt_i;
  // A pending request was issued for the old stream; its response must be thrown away.
  assign stale_gnt = gnt & pending_q & (pending_discard_q | branch_i);

  assign push       = instr_rvalid_i & (discard_q == '0) & ~branch_i;
  assign fifo_empty = (count_q == '0);

`ifdef IBEX_PREFETCH_BYPASS_EN
  assign bypass = push & fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign valid_o  = ~fifo_empty | bypass;
  assign rdata_o  = bypass ? instr_rdata_i : fifo_rdata_q[rptr_q];
  assign err_o    = bypass ? instr_err_i : (~fifo_empty & fifo_err_q[rptr_q]);
  assign addr_o   = out_addr_q;
  assign pop      = valid_o & ready_i;
  assign fifo_pop = pop & ~fifo_empty;
  assign fifo_wr  = push & ~(bypass & ready_i);

  assign busy_o = (outstanding_q != '0) | instr_req_o;

  always_comb begin
    outstanding_d = outstanding_q + CntW'(gnt) - CntW'(instr_rvalid_i);

    discard_d = discard_q;
    if (branch_i) begin
      // Everything in flight now belongs to the old stream.
      discard_d = outstanding_q + CntW'(stale_gnt) - CntW'(instr_rvalid_i);
    end else begin
      discard_d = discard_q - CntW'(instr_rvalid_i & (discard_q != '0)) + CntW'(stale_gnt);
    end

    fetch_addr_d = fetch_addr_q;
    if (new_req) begin
      fetch_addr_d = req_addr_aligned + 32'd4;
    end else if (branch_i) begin
      fetch_addr_d = addr_i & ~32'h3;
    end

    out_addr_d = out_addr_q;
    if (branch_i) begin
      out_addr_d = addr_i;
    end else if (pop) begin
      out_addr_d = {out_addr_q[31:2] + 30'd1, 2'b00};
    end

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (branch_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (fifo_wr)  wptr_d = ptr_inc(wptr_q);
      if (fifo_pop) rptr_d = ptr_inc(rptr_q);
      count_d = count_q + FCntW'(fifo_wr) - FCntW'(fifo_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending_q         <= 1'b0;
      pending_discard_q <= 1'b0;
      stored_addr_q     <= '0;
      fetch_addr_q      <= '0;
      outstanding_q     <= '0;
      discard_q         <= '0;
      out_addr_q        <= '0;
      wptr_q            <= '0;
      rptr_q            <= '0;
      count_q           <= '0;
    end else begin
      pending_q         <= instr_req_o & ~instr_gnt_i;
      pending_discard_q <= pending_q & ~instr_gnt_i & (pending_discard_q | branch_i);
      // Capture the address of a fresh request so it stays stable until granted.
      if (!pending_q) begin
        stored_addr_q <= req_addr_aligned;
      end
      fetch_addr_q  <= fetch_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      out_addr_q    <= out_addr_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
    end
  end

  // Data storage needs no reset: entries are only read when count_q says they are valid.
  always_ff @(posedge clk_i) begin
    if (fifo_wr) begin
      fifo_rdata_q[wptr_q] <= instr_rdata_i;
      fifo_err_q[wptr_q]   <= instr_err_i;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(instr_rvalid_i && outstanding_q == '0))
        else $error("instr_rvalid_i with no outstanding request");
      assert (!(fifo_wr && !fifo_pop && 32'(count_q) == FifoDepth))
        else $error("prefetch FIFO overflow");
    end
  end
`endif

endmodule
